// File: rtl/das_sum_accum_pkg.sv
// Shared types and width helpers for the delay-and-sum accumulator and its neighbours.
package das_sum_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Accumulator width that cannot wrap for num_ch full-scale products.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned apod_en,
                                              input int unsigned num_ch);
        return data_w + ((apod_en != 0) ? coef_w : 0) + $clog2(num_ch);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned num_ch);
        return $clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/das_sum_accum_if.sv
// Sample-in / result-out bus of the delay-and-sum accumulator.
interface das_sum_accum_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned COEF_WIDTH = 8,
    parameter int unsigned OUT_WIDTH  = 18,
    parameter int unsigned CNT_W      = 3
);
    logic                         start_sum;
    logic                         sum_en;
    logic                         sample_ready;
    logic signed [DATA_WIDTH-1:0] delayed_sample;
    logic signed [COEF_WIDTH-1:0] apod_weight;
    logic                         done_channel;
    logic signed [OUT_WIDTH-1:0]  sum_result;
    logic                         valid;
    logic                         out_ready;
    logic                         overflow;
    logic [CNT_W-1:0]             chan_count;
    logic                         busy;

    // Producer/consumer side (delay stage and envelope detector).
    modport master (
        output start_sum, sum_en, delayed_sample, apod_weight, done_channel, out_ready,
        input  sample_ready, sum_result, valid, overflow, chan_count, busy
    );

    // Accumulator side.
    modport slave (
        input  start_sum, sum_en, delayed_sample, apod_weight, done_channel, out_ready,
        output sample_ready, sum_result, valid, overflow, chan_count, busy
    );
endinterface

// File: rtl/das_sum_accum_sat_shift.sv
// Combinational arithmetic right shift followed by clamp or truncation to OUT_W, with overflow flag.
module das_sum_accum_sat_shift #(
    parameter int unsigned IN_W     = 26,
    parameter int unsigned OUT_W    = 18,
    parameter int unsigned SHIFT    = 0,
    parameter int unsigned SATURATE = 1
) (
    input  logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0] result,
    output logic                    overflow
);

    logic signed [IN_W-1:0] shifted;

    assign shifted = value >>> SHIFT;

    if (OUT_W < IN_W) begin : g_narrow
        localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
        localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

        // Value fits when every bit above the output sign bit repeats it.
        logic [IN_W-OUT_W:0] top_bits;
        logic                fits;

        assign top_bits = shifted[IN_W-1:OUT_W-1];
        assign fits     = (top_bits == '0) || (top_bits == '1);
        assign overflow = !fits;

        if (SATURATE != 0) begin : g_sat
            assign result = fits ? shifted[OUT_W-1:0]
                                 : (shifted[IN_W-1] ? SAT_MIN : SAT_MAX);
        end else begin : g_trunc
            assign result = shifted[OUT_W-1:0];
        end
    end else begin : g_wide
        assign result   = OUT_W'(shifted);
        assign overflow = 1'b0;
    end

endmodule

// File: rtl/das_sum_accum.sv
// Delay-and-sum accumulator: weights and sums NUM_CHANNELS samples per focal point and
// hands out one scaled, saturated result through a valid/ready handshake.
module das_sum_accum
    import das_sum_accum_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned COEF_WIDTH   = 8,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned APOD_EN      = 1,
    parameter int unsigned OUT_WIDTH    = 18,
    parameter int unsigned OUT_SHIFT    = 0,
    parameter int unsigned SATURATE     = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    das_sum_accum_if.slave  bus
);

    localparam int unsigned PROD_W = DATA_WIDTH + ((APOD_EN != 0) ? COEF_WIDTH : 0);
    localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, COEF_WIDTH, APOD_EN, NUM_CHANNELS);
    localparam int unsigned CNT_W  = cnt_width(NUM_CHANNELS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHANNELS - 1);

    state_e state_q, state_d;

    logic                     accept_c;
    logic                     clear_c;
    logic signed [PROD_W-1:0] product_c;
    logic signed [ACC_W-1:0]  acc_sum_c;
    logic signed [OUT_WIDTH-1:0] sat_c;
    logic                     ovf_c;

    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         chan_count_q;
    logic signed [OUT_WIDTH-1:0] sum_result_q;
    logic                     valid_q;
    logic                     overflow_q;
    logic                     sample_ready_q;
    logic                     busy_q;

    // Weighted sample for the product register.
    if (APOD_EN != 0) begin : g_apod
        assign product_c = PROD_W'(bus.delayed_sample) * PROD_W'(bus.apod_weight);
    end else begin : g_no_apod
        assign product_c = bus.delayed_sample;
    end

    assign acc_sum_c = acc_q + ACC_W'(prod_q);

    das_sum_accum_sat_shift #(
        .IN_W     (ACC_W),
        .OUT_W    (OUT_WIDTH),
        .SHIFT    (OUT_SHIFT),
        .SATURATE (SATURATE)
    ) u_sat_shift (
        .value    (acc_sum_c),
        .result   (sat_c),
        .overflow (ovf_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; clear_c starts a fresh focal point.
    always_comb begin
        state_d  = state_q;
        clear_c  = 1'b0;
        accept_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_sum) begin
                    state_d = ST_ACCUM;
                    clear_c = 1'b1;
                end
            end
            ST_ACCUM: begin
                accept_c = bus.sum_en;
                if (bus.done_channel || (accept_c && (chan_count_q == LAST_IDX))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    if (bus.start_sum) begin
                        state_d = ST_ACCUM;
                        clear_c = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Two-stage datapath: product register, then accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q       <= '0;
            acc_q        <= '0;
            chan_count_q <= '0;
        end else if (clear_c) begin
            prod_q       <= '0;
            acc_q        <= '0;
            chan_count_q <= '0;
        end else begin
            prod_q <= accept_c ? product_c : '0;
            if ((state_q == ST_ACCUM) || (state_q == ST_DRAIN)) begin
                acc_q <= acc_sum_c;
            end
            if (accept_c) begin
                chan_count_q <= chan_count_q + CNT_W'(1);
            end
        end
    end

    // Result register and handshake flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_result_q   <= '0;
            overflow_q     <= 1'b0;
            valid_q        <= 1'b0;
            sample_ready_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            if (state_q == ST_DRAIN) begin
                sum_result_q <= sat_c;
                overflow_q   <= ovf_c;
                valid_q      <= 1'b1;
            end else if ((state_q == ST_HOLD) && bus.out_ready) begin
                valid_q      <= 1'b0;
            end
            sample_ready_q <= (state_d == ST_ACCUM);
            busy_q         <= (state_d != ST_IDLE);
        end
    end

    assign bus.sum_result   = sum_result_q;
    assign bus.overflow     = overflow_q;
    assign bus.valid        = valid_q;
    assign bus.sample_ready = sample_ready_q;
    assign bus.busy         = busy_q;
    assign bus.chan_count   = chan_count_q;

endmodule

// File: tb/tb_das_sum_accum.sv
// Directed bench for das_sum_accum: default build plus two 16-bit-output builds (clamp, truncate).
module tb_das_sum_accum;

    logic clk;
    logic reset_n;
    logic start_sum, sum_en, done_channel, out_ready;
    logic signed [15:0] delayed_sample;
    logic signed [7:0]  apod_weight;

    int n_cmp  = 0;
    int n_fail = 0;

    das_sum_accum_if #(.DATA_WIDTH(16), .COEF_WIDTH(8), .OUT_WIDTH(18), .CNT_W(3)) if_a ();
    das_sum_accum_if #(.DATA_WIDTH(16), .COEF_WIDTH(8), .OUT_WIDTH(16), .CNT_W(3)) if_s ();
    das_sum_accum_if #(.DATA_WIDTH(16), .COEF_WIDTH(8), .OUT_WIDTH(16), .CNT_W(3)) if_t ();

    assign if_a.start_sum = start_sum;      assign if_s.start_sum = start_sum;      assign if_t.start_sum = start_sum;
    assign if_a.sum_en = sum_en;            assign if_s.sum_en = sum_en;            assign if_t.sum_en = sum_en;
    assign if_a.done_channel = done_channel; assign if_s.done_channel = done_channel; assign if_t.done_channel = done_channel;
    assign if_a.out_ready = out_ready;      assign if_s.out_ready = out_ready;      assign if_t.out_ready = out_ready;
    assign if_a.delayed_sample = delayed_sample; assign if_s.delayed_sample = delayed_sample; assign if_t.delayed_sample = delayed_sample;
    assign if_a.apod_weight = apod_weight;  assign if_s.apod_weight = apod_weight;  assign if_t.apod_weight = apod_weight;

    das_sum_accum #(.OUT_WIDTH(18), .SATURATE(1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    das_sum_accum #(.OUT_WIDTH(16), .SATURATE(1)) dut_s (.clk(clk), .reset_n(reset_n), .bus(if_s));
    das_sum_accum #(.OUT_WIDTH(16), .SATURATE(0)) dut_t (.clk(clk), .reset_n(reset_n), .bus(if_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic start_focal();
        @(negedge clk);
        start_sum = 1'b1;
        @(posedge clk); #1;
        start_sum = 1'b0;
    endtask

    task automatic put(input int s, input int w, input bit done);
        @(negedge clk);
        sum_en         = 1'b1;
        delayed_sample = 16'(s);
        apod_weight    = 8'(w);
        done_channel   = done;
        @(posedge clk); #1;
        sum_en       = 1'b0;
        done_channel = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start_sum = 1'b0; sum_en = 1'b0; done_channel = 1'b0;
        out_ready = 1'b0; delayed_sample = '0; apod_weight = '0;
        #1;
        check("rst_valid",  32'(if_a.valid), 32'd0);
        check("rst_result", 32'(if_a.sum_result), 32'd0);
        check("rst_ready",  32'(if_a.sample_ready), 32'd0);
        check("rst_busy",   32'(if_a.busy), 32'd0);
        check("rst_count",  32'(if_a.chan_count), 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // 1: unity weights
        start_focal();
        check("t1_ready", 32'(if_a.sample_ready), 32'd1);
        put(237, 1, 0); put(1987, 1, 0); put(125, 1, 0); put(5230, 1, 0);
        check("t1_ready_off", 32'(if_a.sample_ready), 32'd0);
        check("t1_valid_early", 32'(if_a.valid), 32'd0);
        tick();
        check("t1_valid",  32'(if_a.valid), 32'd1);
        check("t1_result", 32'(if_a.sum_result), 32'd7579);
        check("t1_count",  32'(if_a.chan_count), 32'd4);
        check("t1_ovf",    32'(if_a.overflow), 32'd0);
        take();
        check("t1_valid_clr", 32'(if_a.valid), 32'd0);
        check("t1_busy_clr",  32'(if_a.busy), 32'd0);

        // 2: signed weights
        start_focal();
        put(237, 2, 0); put(1987, -1, 0); put(125, 3, 0); put(5230, 0, 0);
        tick();
        check("t2_result", 32'(if_a.sum_result), -32'sd1138);
        check("t2_valid",  32'(if_a.valid), 32'd1);
        take();

        // 3: full-scale samples
        start_focal();
        for (int i = 0; i < 4; i++) put(32767, 1, 0);
        tick();
        check("t3_wide_result", 32'(if_a.sum_result), 32'd131068);
        check("t3_wide_ovf",    32'(if_a.overflow), 32'd0);
        check("t3_sat_result",  32'(if_s.sum_result), 32'd32767);
        check("t3_sat_ovf",     32'(if_s.overflow), 32'd1);
        check("t3_trunc_result", {16'd0, if_t.sum_result}, 32'h0000FFFC);
        check("t3_trunc_ovf",   32'(if_t.overflow), 32'd1);
        take();

        // 4: early termination
        start_focal();
        put(237, 1, 0); put(1987, 1, 1);
        check("t4_ready_off", 32'(if_a.sample_ready), 32'd0);
        tick();
        check("t4_result", 32'(if_a.sum_result), 32'd2224);
        check("t4_count",  32'(if_a.chan_count), 32'd2);
        take();
        start_focal();
        @(negedge clk); done_channel = 1'b1;
        @(posedge clk); #1; done_channel = 1'b0;
        tick();
        check("t4_zero_valid",  32'(if_a.valid), 32'd1);
        check("t4_zero_result", 32'(if_a.sum_result), 32'd0);
        check("t4_zero_count",  32'(if_a.chan_count), 32'd0);
        take();

        // 5: back-pressure then back-to-back start
        start_focal();
        put(100, 1, 0); put(200, 1, 0); put(300, 1, 0); put(400, 1, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); start_sum = 1'b1;
            @(posedge clk); #1;
            check("t5_hold_valid",  32'(if_a.valid), 32'd1);
            check("t5_hold_result", 32'(if_a.sum_result), 32'd1000);
            check("t5_hold_ready",  32'(if_a.sample_ready), 32'd0);
        end
        @(negedge clk); start_sum = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; start_sum = 1'b0; out_ready = 1'b0;
        check("t5_b2b_valid", 32'(if_a.valid), 32'd0);
        check("t5_b2b_ready", 32'(if_a.sample_ready), 32'd1);
        check("t5_b2b_count", 32'(if_a.chan_count), 32'd0);
        put(10, 1, 0); put(20, 1, 0); put(30, 1, 0); put(40, 1, 0);
        tick();
        check("t5_new_result", 32'(if_a.sum_result), 32'd100);
        take();

        // 6: asynchronous reset mid-accumulation
        start_focal();
        put(500, 1, 0); put(600, 1, 0);
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("t6_rst_result", 32'(if_a.sum_result), 32'd0);
        check("t6_rst_count",  32'(if_a.chan_count), 32'd0);
        check("t6_rst_ready",  32'(if_a.sample_ready), 32'd0);
        check("t6_rst_busy",   32'(if_a.busy), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        start_focal();
        put(237, 1, 0); put(1987, 1, 0); put(125, 1, 0); put(5230, 1, 0);
        tick();
        check("t6_fresh_result", 32'(if_a.sum_result), 32'd7579);
        check("t6_fresh_count",  32'(if_a.chan_count), 32'd4);
        take();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
